// File: rtl/i2s_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// i2s_pkg : shared widths and state encoding for the I2S receiver
// Revision 1.0
// ------------------------------------------------------------------
package i2s_pkg;
    localparam int SAMPLE_WIDTH = 16;
    localparam int ERR_CNT_W    = 8;
    localparam int BIT_CNT_W    = $clog2(2 * SAMPLE_WIDTH + 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ALIGN    = 2'd1,
        LOCKED   = 2'd2
    } rx_state_t;
endpackage
`default_nettype wire

// File: rtl/i2s_receiver_if.sv
`default_nettype none
// ------------------------------------------------------------------
// i2s_receiver_if : serial input and parallel pair output of the receiver
// Revision 1.0
// ------------------------------------------------------------------
interface i2s_receiver_if #(
    parameter int SAMPLE_WIDTH = i2s_pkg::SAMPLE_WIDTH,
    parameter int ERR_CNT_W    = i2s_pkg::ERR_CNT_W
);
    logic                    word_select;
    logic                    sound_bit_in;
    logic                    sample_ready;
    logic [SAMPLE_WIDTH-1:0] left_sample;
    logic [SAMPLE_WIDTH-1:0] right_sample;
    logic                    sample_valid;
    logic                    locked;
    logic                    overrun;
    logic [ERR_CNT_W-1:0]    frame_error_count;

    modport master (
        input  word_select, sound_bit_in, sample_ready,
        output left_sample, right_sample, sample_valid, locked, overrun, frame_error_count
    );

    modport slave (
        output word_select, sound_bit_in, sample_ready,
        input  left_sample, right_sample, sample_valid, locked, overrun, frame_error_count
    );
endinterface
`default_nettype wire

// File: rtl/i2s_rx_deserializer.sv
`default_nettype none
// ------------------------------------------------------------------
// i2s_rx_deserializer : input capture, slot boundary detection and word assembly
// Revision 1.0
// ------------------------------------------------------------------
module i2s_rx_deserializer
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = i2s_pkg::SAMPLE_WIDTH
) (
    input  wire logic                    serial_clk,
    input  wire logic                    reset,
    input  wire logic                    word_select,
    input  wire logic                    sound_bit_in,
    output logic [SAMPLE_WIDTH-1:0]      word,
    output logic                         word_strobe,
    output logic                         word_is_left,
    output logic                         word_ok,
    output logic                         timeout
);
    localparam int c_bit_cnt_w = $clog2(2 * SAMPLE_WIDTH + 1);
    localparam logic [c_bit_cnt_w-1:0] c_word_last = c_bit_cnt_w'(SAMPLE_WIDTH - 1);
    localparam logic [c_bit_cnt_w-1:0] c_cnt_max   = c_bit_cnt_w'(2 * SAMPLE_WIDTH);

    logic                    ws_q, ws_d;
    logic                    ws_qq, ws_qq_d;
    logic                    sd_q, sd_d;
    logic                    hist_seen_q, hist_seen_d;
    logic                    hist_valid_q, hist_valid_d;
    logic [SAMPLE_WIDTH-2:0] shift_q, shift_d;
    logic [c_bit_cnt_w-1:0]  bit_cnt_q, bit_cnt_d;
    logic                    w_trans;

    // ws_qq only holds a real sample from the second edge after reset.
    assign w_trans = hist_valid_q && (ws_q != ws_qq);

    always_comb begin
        ws_d         = word_select;
        sd_d         = sound_bit_in;
        ws_qq_d      = ws_q;
        hist_seen_d  = 1'b1;
        hist_valid_d = hist_seen_q;
        shift_d      = {shift_q[SAMPLE_WIDTH-3:0], sd_q};
        if (w_trans) begin
            bit_cnt_d = '0;
        end else if (bit_cnt_q == c_cnt_max) begin
            bit_cnt_d = bit_cnt_q;
        end else begin
            bit_cnt_d = bit_cnt_q + c_bit_cnt_w'(1);
        end
    end

    always_ff @(posedge serial_clk) begin
        if (reset) begin
            ws_q         <= 1'b0;
            ws_qq        <= 1'b0;
            sd_q         <= 1'b0;
            hist_seen_q  <= 1'b0;
            hist_valid_q <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
        end else begin
            ws_q         <= ws_d;
            ws_qq        <= ws_qq_d;
            sd_q         <= sd_d;
            hist_seen_q  <= hist_seen_d;
            hist_valid_q <= hist_valid_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

    // The bit captured alongside the new word_select is the LSB of the closing slot.
    assign word         = {shift_q, sd_q};
    assign word_strobe  = w_trans;
    assign word_is_left = ws_q;
    assign word_ok      = (bit_cnt_q == c_word_last);
    assign timeout      = !w_trans && (bit_cnt_q == c_cnt_max);
endmodule
`default_nettype wire

// File: rtl/i2s_receiver.sv
`default_nettype none
// ------------------------------------------------------------------
// i2s_receiver : I2S receiver with framing lock, L/R pairing and valid/ready output
// Revision 1.0
// ------------------------------------------------------------------
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = i2s_pkg::SAMPLE_WIDTH,
    parameter int ERR_CNT_W    = i2s_pkg::ERR_CNT_W
) (
    input  wire logic      serial_clk,
    input  wire logic      reset,
    i2s_receiver_if.master bus
);
    logic [SAMPLE_WIDTH-1:0] word;
    logic                    word_strobe;
    logic                    word_is_left;
    logic                    word_ok;
    logic                    timeout;

    rx_state_t               state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] pending_left_q, pending_left_d;
    logic                    pending_valid_q, pending_valid_d;
    logic [SAMPLE_WIDTH-1:0] left_q, left_d;
    logic [SAMPLE_WIDTH-1:0] right_q, right_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic                    w_publish;
    logic                    w_accept;

    i2s_rx_deserializer #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_deser (
        .serial_clk   (serial_clk),
        .reset        (reset),
        .word_select  (bus.word_select),
        .sound_bit_in (bus.sound_bit_in),
        .word         (word),
        .word_strobe  (word_strobe),
        .word_is_left (word_is_left),
        .word_ok      (word_ok),
        .timeout      (timeout)
    );

    assign w_accept = valid_q && bus.sample_ready;

    always_comb begin
        state_d         = state_q;
        pending_left_d  = pending_left_q;
        pending_valid_d = pending_valid_q;
        err_cnt_d       = err_cnt_q;
        w_publish       = 1'b0;

        if (timeout) begin
            state_d         = UNLOCKED;
            pending_valid_d = 1'b0;
        end else if (word_strobe) begin
            case (state_q)
                UNLOCKED: state_d = ALIGN;
                ALIGN: begin
                    // The word that completes alignment is never used.
                    if (word_ok) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (!word_ok) begin
                        state_d         = ALIGN;
                        pending_valid_d = 1'b0;
                        if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                    end else if (word_is_left) begin
                        pending_left_d  = word;
                        pending_valid_d = 1'b1;
                    end else if (pending_valid_q) begin
                        w_publish       = 1'b1;
                        pending_valid_d = 1'b0;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_comb begin
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (w_accept) begin
            valid_d = 1'b0;
        end
        // A held, unaccepted pair wins over a newly completed one.
        if (w_publish) begin
            if (!valid_q || bus.sample_ready) begin
                left_d  = pending_left_q;
                right_d = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge serial_clk) begin
        if (reset) begin
            state_q         <= UNLOCKED;
            pending_left_q  <= '0;
            pending_valid_q <= 1'b0;
            left_q          <= '0;
            right_q         <= '0;
            valid_q         <= 1'b0;
            overrun_q       <= 1'b0;
            err_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            pending_left_q  <= pending_left_d;
            pending_valid_q <= pending_valid_d;
            left_q          <= left_d;
            right_q         <= right_d;
            valid_q         <= valid_d;
            overrun_q       <= overrun_d;
            err_cnt_q       <= err_cnt_d;
        end
    end

    assign bus.left_sample       = left_q;
    assign bus.right_sample      = right_q;
    assign bus.sample_valid      = valid_q;
    assign bus.locked            = (state_q == LOCKED);
    assign bus.overrun           = overrun_q;
    assign bus.frame_error_count = err_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_i2s_receiver.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_i2s_receiver : directed self-checking bench for i2s_receiver
// Revision 1.0
// ------------------------------------------------------------------
module tb_i2s_receiver;
    import i2s_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2s_receiver_if bus ();

    i2s_receiver dut (
        .serial_clk (clk),
        .reset      (rst),
        .bus        (bus)
    );

    int          n_asserts  = 0;
    int          n_failures = 0;
    int          cycle      = 0;
    logic        prev_lsb   = 1'b0;
    logic [15:0] acc_l[$];
    logic [15:0] acc_r[$];
    int          acc_cyc[$];

    // One transmitter edge: record any handshake completing at this edge, then launch ws/sd.
    task automatic tick(input logic ws, input logic sd);
        if (bus.sample_valid === 1'b1 && bus.sample_ready === 1'b1) begin
            acc_l.push_back(bus.left_sample);
            acc_r.push_back(bus.right_sample);
            acc_cyc.push_back(cycle + 1);
        end
        @(posedge clk);
        cycle++;
        #1;
        bus.word_select  = ws;
        bus.sound_bit_in = sd;
        @(negedge clk);
    endtask

    task automatic send_slot(input logic ws, input logic [15:0] w, input int len);
        tick(ws, prev_lsb);
        for (int i = len - 1; i >= 1; i--) tick(ws, w[i]);
        prev_lsb = w[0];
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, 16);
        send_slot(1'b1, r, 16);
    endtask

    task automatic clear_acc();
        acc_l.delete();
        acc_r.delete();
        acc_cyc.delete();
    endtask

    task automatic test_reset();
        bus.word_select  = 1'b0;
        bus.sound_bit_in = 1'b0;
        bus.sample_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick(1'b0, 1'b0);
        n_asserts++;
        if (bus.sample_valid !== 1'b0 || bus.locked !== 1'b0 || bus.overrun !== 1'b0) begin
            n_failures++;
            $display("FAIL reset_flags: valid=%b locked=%b overrun=%b required 0/0/0",
                     bus.sample_valid, bus.locked, bus.overrun);
        end
        n_asserts++;
        if (bus.left_sample !== 16'h0 || bus.right_sample !== 16'h0 || bus.frame_error_count !== 8'h0) begin
            n_failures++;
            $display("FAIL reset_data: left=%h right=%h errs=%h required 0",
                     bus.left_sample, bus.right_sample, bus.frame_error_count);
        end
        rst = 1'b0;
        prev_lsb = 1'b0;
    endtask

    task automatic test_ideal();
        clear_acc();
        send_frame(16'h1234, 16'hBEEF);
        n_asserts++;
        if (bus.locked !== 1'b0) begin
            n_failures++;
            $display("FAIL ideal_unlocked_after_first_transition: locked=%b required 0", bus.locked);
        end
        send_slot(1'b0, 16'h1234, 16);
        n_asserts++;
        if (bus.locked !== 1'b1) begin
            n_failures++;
            $display("FAIL ideal_locked_after_second_transition: locked=%b required 1", bus.locked);
        end
        send_slot(1'b1, 16'hBEEF, 16);
        send_frame(16'h1234, 16'hBEEF);
        send_frame(16'h1234, 16'hBEEF);
        n_asserts++;
        if (acc_l.size() != 2) begin
            n_failures++;
            $display("FAIL ideal_pair_count: got %0d required 2", acc_l.size());
        end else begin
            n_asserts++;
            if (acc_l[0] !== 16'h1234 || acc_r[0] !== 16'hBEEF) begin
                n_failures++;
                $display("FAIL ideal_pair_value: got %h/%h required 1234/beef", acc_l[0], acc_r[0]);
            end
            n_asserts++;
            if (acc_cyc[1] - acc_cyc[0] != 32) begin
                n_failures++;
                $display("FAIL ideal_pair_spacing: got %0d required 32", acc_cyc[1] - acc_cyc[0]);
            end
        end
        n_asserts++;
        if (bus.frame_error_count !== 8'h0) begin
            n_failures++;
            $display("FAIL ideal_no_errors: got %0d required 0", bus.frame_error_count);
        end
    endtask

    task automatic test_latency();
        logic [15:0] l = 16'hA5C3;
        logic [15:0] r = 16'h0F1E;
        logic v0, v1, v2;
        logic [15:0] l2;
        clear_acc();
        tick(1'b0, prev_lsb);
        v0 = bus.sample_valid;
        tick(1'b0, l[15]);
        v1 = bus.sample_valid;
        tick(1'b0, l[14]);
        v2 = bus.sample_valid;
        l2 = bus.left_sample;
        n_asserts++;
        if (v0 !== 1'b0 || v1 !== 1'b0 || v2 !== 1'b1) begin
            n_failures++;
            $display("FAIL latency_valid_edges: got %b%b%b required 001", v0, v1, v2);
        end
        n_asserts++;
        if (l2 !== 16'h1234) begin
            n_failures++;
            $display("FAIL latency_left_value: got %h required 1234", l2);
        end
        for (int i = 13; i >= 1; i--) tick(1'b0, l[i]);
        prev_lsb = l[0];
        send_slot(1'b1, r, 16);
    endtask

    task automatic test_backpressure();
        clear_acc();
        bus.sample_ready = 1'b0;
        send_frame(16'h1111, 16'h2222);
        n_asserts++;
        if (bus.overrun !== 1'b0) begin
            n_failures++;
            $display("FAIL bp_no_early_overrun: got %b required 0", bus.overrun);
        end
        send_frame(16'h3333, 16'h4444);
        send_frame(16'h5555, 16'h6666);
        n_asserts++;
        if (bus.sample_valid !== 1'b1 || bus.left_sample !== 16'hA5C3 || bus.right_sample !== 16'h0F1E) begin
            n_failures++;
            $display("FAIL bp_held_pair: got valid=%b %h/%h required 1 a5c3/0f1e",
                     bus.sample_valid, bus.left_sample, bus.right_sample);
        end
        n_asserts++;
        if (bus.overrun !== 1'b1) begin
            n_failures++;
            $display("FAIL bp_overrun_set: got %b required 1", bus.overrun);
        end
        bus.sample_ready = 1'b1;
        send_frame(16'h7777, 16'h8888);
        send_frame(16'h9999, 16'hAAAA);
        n_asserts++;
        if (acc_l.size() != 3) begin
            n_failures++;
            $display("FAIL bp_pair_count: got %0d required 3", acc_l.size());
        end else begin
            n_asserts++;
            if (acc_l[0] !== 16'hA5C3 || acc_r[0] !== 16'h0F1E) begin
                n_failures++;
                $display("FAIL bp_first_accept: got %h/%h required a5c3/0f1e", acc_l[0], acc_r[0]);
            end
            n_asserts++;
            if (acc_l[1] !== 16'h5555 || acc_r[1] !== 16'h6666) begin
                n_failures++;
                $display("FAIL bp_next_pair: got %h/%h required 5555/6666", acc_l[1], acc_r[1]);
            end
            n_asserts++;
            if (acc_l[2] !== 16'h7777 || acc_r[2] !== 16'h8888) begin
                n_failures++;
                $display("FAIL bp_resumed_pair: got %h/%h required 7777/8888", acc_l[2], acc_r[2]);
            end
        end
        n_asserts++;
        if (bus.overrun !== 1'b1) begin
            n_failures++;
            $display("FAIL bp_overrun_sticky: got %b required 1", bus.overrun);
        end
    endtask

    task automatic test_framing_error();
        clear_acc();
        send_slot(1'b0, 16'hDEAD, 15);
        send_slot(1'b1, 16'hC0DE, 16);
        n_asserts++;
        if (bus.frame_error_count !== 8'd1 || bus.locked !== 1'b0) begin
            n_failures++;
            $display("FAIL fe_error_detect: errs=%0d locked=%b required 1/0",
                     bus.frame_error_count, bus.locked);
        end
        send_slot(1'b0, 16'h1357, 16);
        n_asserts++;
        if (bus.locked !== 1'b1) begin
            n_failures++;
            $display("FAIL fe_relock: locked=%b required 1", bus.locked);
        end
        send_slot(1'b1, 16'h2468, 16);
        send_frame(16'h4321, 16'h8765);
        n_asserts++;
        if (acc_l.size() != 2) begin
            n_failures++;
            $display("FAIL fe_pair_count: got %0d required 2", acc_l.size());
        end else begin
            n_asserts++;
            if (acc_l[0] !== 16'h9999 || acc_r[0] !== 16'hAAAA || acc_l[1] !== 16'h1357 || acc_r[1] !== 16'h2468) begin
                n_failures++;
                $display("FAIL fe_pairs: got %h/%h %h/%h required 9999/aaaa 1357/2468",
                         acc_l[0], acc_r[0], acc_l[1], acc_r[1]);
            end
        end
        n_asserts++;
        if (bus.frame_error_count !== 8'd1) begin
            n_failures++;
            $display("FAIL fe_error_stable: got %0d required 1", bus.frame_error_count);
        end
    endtask

    task automatic test_timeout();
        clear_acc();
        send_slot(1'b0, 16'hF00D, 16);
        repeat (40) tick(1'b1, 1'b0);
        prev_lsb = 1'b0;
        n_asserts++;
        if (bus.locked !== 1'b0 || dut.state_q !== UNLOCKED) begin
            n_failures++;
            $display("FAIL to_unlocked: locked=%b state=%0d required 0/%0d",
                     bus.locked, dut.state_q, UNLOCKED);
        end
        send_frame(16'h0101, 16'h0202);
        n_asserts++;
        if (bus.locked !== 1'b1) begin
            n_failures++;
            $display("FAIL to_relock: locked=%b required 1", bus.locked);
        end
        send_frame(16'h0303, 16'h0404);
        send_frame(16'h0505, 16'h0606);
        n_asserts++;
        if (acc_l.size() != 2) begin
            n_failures++;
            $display("FAIL to_pair_count: got %0d required 2", acc_l.size());
        end else begin
            n_asserts++;
            if (acc_l[0] !== 16'h4321 || acc_r[0] !== 16'h8765 || acc_l[1] !== 16'h0303 || acc_r[1] !== 16'h0404) begin
                n_failures++;
                $display("FAIL to_pairs: got %h/%h %h/%h required 4321/8765 0303/0404",
                         acc_l[0], acc_r[0], acc_l[1], acc_r[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] l = 16'hCAFE;
        bus.sample_ready = 1'b0;
        tick(1'b0, prev_lsb);
        for (int i = 15; i >= 8; i--) tick(1'b0, l[i]);
        n_asserts++;
        if (bus.sample_valid !== 1'b1 || bus.left_sample !== 16'h0505) begin
            n_failures++;
            $display("FAIL rm_pre_reset_pair: valid=%b left=%h required 1/0505",
                     bus.sample_valid, bus.left_sample);
        end
        rst = 1'b1;
        tick(1'b1, 1'b0);
        n_asserts++;
        if (bus.sample_valid !== 1'b0 || bus.left_sample !== 16'h0 || bus.right_sample !== 16'h0 ||
            bus.locked !== 1'b0 || bus.overrun !== 1'b0 || bus.frame_error_count !== 8'h0) begin
            n_failures++;
            $display("FAIL rm_outputs_cleared: valid=%b l=%h r=%h locked=%b ovr=%b errs=%0d required all 0",
                     bus.sample_valid, bus.left_sample, bus.right_sample, bus.locked,
                     bus.overrun, bus.frame_error_count);
        end
        tick(1'b1, 1'b0);
        rst = 1'b0;
        bus.sample_ready = 1'b1;
        prev_lsb = 1'b0;
        clear_acc();
        repeat (8) tick(1'b1, 1'b0);
        send_frame(16'h7E57, 16'h1DEA);
        n_asserts++;
        if (bus.frame_error_count !== 8'h0 || bus.locked !== 1'b1) begin
            n_failures++;
            $display("FAIL rm_relock_no_error: errs=%0d locked=%b required 0/1",
                     bus.frame_error_count, bus.locked);
        end
        send_frame(16'h6B6B, 16'h7C7C);
        n_asserts++;
        if (acc_l.size() != 0) begin
            n_failures++;
            $display("FAIL rm_no_spurious_pair: got %0d pairs required 0", acc_l.size());
        end
        send_slot(1'b0, 16'h0000, 16);
        n_asserts++;
        if (acc_l.size() != 1) begin
            n_failures++;
            $display("FAIL rm_first_pair_count: got %0d required 1", acc_l.size());
        end else begin
            n_asserts++;
            if (acc_l[0] !== 16'h6B6B || acc_r[0] !== 16'h7C7C) begin
                n_failures++;
                $display("FAIL rm_first_pair: got %h/%h required 6b6b/7c7c", acc_l[0], acc_r[0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ideal();
        test_latency();
        test_backpressure();
        test_framing_error();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
        $finish;
    end
endmodule
`default_nettype wire
